fixed_accumulator: RTL
======================

// Module: fixed_accumulator
// PURPOSE
//  Integrates ACC_LEN valid fixed-point samples and emits the sum as a wider word.
//  Sits directly upstream of convert: convert narrows the result to the output format.
//  Output binary point equals input binary point; realignment is convert's job.
//  Frames are restarted by a sync pulse. Results saturate on overflow, with a flag.
// PARAMETERS
//  N_BITS_IN   4   input word width
//  BIN_PT_IN   4   input binary point (bits after point); output uses the same value
//  N_BITS_OUT  6   output word width, >= N_BITS_IN
//  ACC_LEN     4   samples per frame, >= 2
//  IS_SIGNED   0   1: two's complement in/out; 0: unsigned in/out
// PORTS
//  clk       in   1           rising-edge clock
//  rst_n     in   1           synchronous reset, active low
//  sync      in   1           frame restart pulse
//  din_vld   in   1           din qualifier
//  din       in   N_BITS_IN   sample
//  dout      out  N_BITS_OUT  frame sum, saturated
//  dout_vld  out  1           one-cycle strobe: dout and dout_ovf are valid
//  dout_ovf  out  1           frame saturated, valid with dout_vld
// BEHAVIOUR
//  Reset: rst_n low at a clk edge forces state IDLE, acc=0, cnt=0, dout=0, dout_vld=0,
//   dout_ovf=0. Reset overrides all other inputs, including mid-frame; the partial frame is lost.
//  States: IDLE and RUN. IDLE ignores din_vld. sync in any state moves to RUN.
//  On sync: acc=0, cnt=0, sticky ovf=0. If din_vld=1 in the same cycle, that din is sample 0
//   of the new frame.
//  RUN with din_vld=1 and no sync: acc=sat(acc+ext(din)); cnt++ (width $clog2(ACC_LEN)).
//  Extension: sign-extend if IS_SIGNED, else zero-extend, to N_BITS_OUT+1 bits before add.
//  Saturation limits:
//   unsigned: max 2^N_BITS_OUT-1.
//   signed: max 2^(N_BITS_OUT-1)-1, min -2^(N_BITS_OUT-1).
//   When clamped, set sticky ovf; it stays set until the frame ends.
//  Final sample (cnt==ACC_LEN-1 with din_vld):
//   next cycle, dout=sat(acc+ext(din)), dout_ovf=ovf|this-add-ovf, dout_vld=1 for one cycle.
//   Same edge: acc=0, cnt=0, ovf=0. The next valid sample, even in the following cycle,
//   starts a new frame, so continuous din_vld loses no samples.
//  Latency: 1 clk from the final sample edge to dout_vld.
//  dout holds its value between strobes. dout_vld=0 otherwise.
//  sync coinciding with a final sample: sync wins; no dump; the sample is counted per the sync rule.
//  Gaps in din_vld are allowed; only valid cycles count.
//  No backpressure: the downstream block must accept dout_vld unconditionally.
// STRUCTURE
//  fixed_defs.vh (shared include):
//   clog2 constant function; sat-limit localparam macros (max/min per IS_SIGNED, width);
//   reused by convert.
//  Sub-module sat_add #(W, IS_SIGNED):
//   combinational (W+1)-bit add, clamp to W bits, ovf flag.
//   The accumulator instantiates one; the FSM, counter and registers stay in fixed_accumulator.
// TESTING  (defaults unless noted; one self-checking instance per config, like convert_tb)
//  1 Reset: rst_n=0 for 2 clk with din_vld=1 -> dout=0, dout_vld=0, dout_ovf=0; no dump.
//  2 Basic: sync, then 4 cycles din=4'b0100 (0.25) -> 1 clk after 4th:
//     dout=6'b010000 (1.0), dout_vld=1 for 1 clk, dout_ovf=0.
//  3 Gaps: same 4 samples with din_vld low 1-3 clk between them -> identical dout, same 1-clk latency.
//  4 Saturation:
//    N_BITS_OUT=5, unsigned: 4x 4'b1111 -> dout=5'b11111, dout_ovf=1.
//    IS_SIGNED=1, N_BITS_OUT=5: 4x 4'b1000 -> dout=5'b10000, dout_ovf=1.
//  5 Mid-frame sync: 2 samples 4'b0111, then sync with din=4'b0001, then 3x 4'b0001
//     -> single dump dout=6'b000100; no dump for the aborted frame.
//  6 Back-to-back: continuous din_vld, din=4'b0001, 12 cycles after sync
//     -> dout_vld every 4th clk, 3 strobes, each dout=6'b000100, dout_ovf=0.

Source files
------------

// File: rtl/fixed_accumulator_pkg.sv
// Shared definitions for the fixed-point accumulator: FSM state encoding and
// a constant-evaluable ceil(log2) used to size the sample counter.
package fixed_accumulator_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // ceil(log2(v)) for v >= 1; usable in parameter/localparam expressions
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fixed_accumulator_sat_add.sv
// Combinational saturating adder: adds two W-bit words in W+1 bits, clamps
// the result back to W bits and flags when the clamp was applied.
module fixed_accumulator_sat_add #(
  parameter int W         = 6,
  parameter int IS_SIGNED = 0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         ovf
);

  logic [W:0] sum;

  // Returns {ovf, clamped value}. Unsigned overflow shows as a carry out;
  // signed overflow shows as the two top bits disagreeing, with the top bit
  // giving the true sign of the result.
  function automatic logic [W:0] clamp(input logic [W:0] s);
    logic [W:0] r;
    if (IS_SIGNED != 0) begin
      if (s[W] != s[W-1]) begin
        r = s[W] ? {1'b1, 1'b1, {(W-1){1'b0}}} : {1'b1, 1'b0, {(W-1){1'b1}}};
      end else begin
        r = {1'b0, s[W-1:0]};
      end
    end else begin
      r = s[W] ? {1'b1, {W{1'b1}}} : {1'b0, s[W-1:0]};
    end
    return r;
  endfunction

  // Extended-width add followed by clamp to the W-bit range
  always_comb begin
    if (IS_SIGNED != 0) begin
      sum = {a[W-1], a} + {b[W-1], b};
    end else begin
      sum = {1'b0, a} + {1'b0, b};
    end
    {ovf, y} = clamp(sum);
  end

endmodule

// File: rtl/fixed_accumulator.sv
// Frame integrator: sums ACC_LEN valid samples into a wider saturating word
// and emits the sum with a one-cycle strobe. The binary point is unchanged;
// narrowing/realignment happens in the downstream convert block.
module fixed_accumulator
  import fixed_accumulator_pkg::*;
#(
  parameter int N_BITS_IN  = 4,
  parameter int BIN_PT_IN  = 4,
  parameter int N_BITS_OUT = 6,
  parameter int ACC_LEN    = 4,
  parameter int IS_SIGNED  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sync,
  input  logic                  din_vld,
  input  logic [N_BITS_IN-1:0]  din,
  output logic [N_BITS_OUT-1:0] dout,
  output logic                  dout_vld,
  output logic                  dout_ovf
);

  localparam int              CNT_W    = clog2(ACC_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

  state_t                state_q, state_d;
  logic [N_BITS_OUT-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic [N_BITS_OUT-1:0] dout_q, dout_d;
  logic                  dout_vld_q, dout_vld_d;
  logic                  dout_ovf_q, dout_ovf_d;

  logic [N_BITS_OUT-1:0] din_ext;
  logic [N_BITS_OUT-1:0] add_a;
  logic [N_BITS_OUT-1:0] add_y;
  logic                  add_ovf;

  // Widen the sample to accumulator width, honouring signedness
  if (IS_SIGNED != 0) begin : g_sext
    assign din_ext = N_BITS_OUT'($signed(din));
  end else begin : g_zext
    assign din_ext = N_BITS_OUT'(din);
  end

  // A sync cycle starts from an empty accumulator, so its sample adds to zero
  assign add_a = sync ? '0 : acc_q;

  fixed_accumulator_sat_add #(
    .W         (N_BITS_OUT),
    .IS_SIGNED (IS_SIGNED)
  ) u_sat_add (
    .a   (add_a),
    .b   (din_ext),
    .y   (add_y),
    .ovf (add_ovf)
  );

  // Next-state logic: frame restart, sample accumulation and end-of-frame dump
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    dout_d     = dout_q;
    dout_ovf_d = dout_ovf_q;
    dout_vld_d = 1'b0;
    if (sync) begin
      state_d = ST_RUN;
      if (din_vld) begin
        acc_d = add_y;
        cnt_d = CNT_W'(1);
        ovf_d = add_ovf;
      end else begin
        acc_d = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
      end
    end else if (state_q == ST_RUN && din_vld) begin
      if (cnt_q == CNT_LAST) begin
        dout_d     = add_y;
        dout_ovf_d = ovf_q | add_ovf;
        dout_vld_d = 1'b1;
        acc_d      = '0;
        cnt_d      = '0;
        ovf_d      = 1'b0;
      end else begin
        acc_d = add_y;
        cnt_d = cnt_q + CNT_W'(1);
        ovf_d = ovf_q | add_ovf;
      end
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      dout_ovf_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      dout_ovf_q <= dout_ovf_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign dout_ovf = dout_ovf_q;

endmodule
